// File: rtl/writeback_merge_queue.sv
// Per-source result FIFOs merged round-robin onto one registered register-file write port.
// Latency 2 edges enqueue-to-strobe when uncontended; src_ready drops only when a queue is full.
module writeback_merge_queue #(
   parameter int NUM_SOURCES      = 3,
   parameter int QUEUE_DEPTH      = 4,
   parameter int DATA_WIDTH       = 512,
   parameter int MASK_WIDTH       = 16,
   parameter int THREAD_IDX_WIDTH = 2,
   parameter int REG_IDX_WIDTH    = 5
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_SOURCES-1:0]                  src_valid,
   output logic [NUM_SOURCES-1:0]                  src_ready,
   input  logic [NUM_SOURCES*THREAD_IDX_WIDTH-1:0] src_thread_idx,
   input  logic [NUM_SOURCES*REG_IDX_WIDTH-1:0]    src_reg,
   input  logic [NUM_SOURCES-1:0]                  src_is_vector,
   input  logic [NUM_SOURCES*DATA_WIDTH-1:0]       src_value,
   input  logic [NUM_SOURCES*MASK_WIDTH-1:0]       src_mask,
   input  logic [NUM_SOURCES-1:0]                  src_is_last_subcycle,
   input  logic                                    rollback_en,
   input  logic [THREAD_IDX_WIDTH-1:0]             rollback_thread_idx,
   output logic                                    wb_writeback_en,
   output logic [THREAD_IDX_WIDTH-1:0]             wb_writeback_thread_idx,
   output logic [REG_IDX_WIDTH-1:0]                wb_writeback_reg,
   output logic                                    wb_writeback_is_vector,
   output logic [DATA_WIDTH-1:0]                   wb_writeback_value,
   output logic [MASK_WIDTH-1:0]                   wb_writeback_mask,
   output logic                                    wb_writeback_is_last_subcycle,
   output logic                                    perf_writeback_stall
);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SRC_W = $clog2(NUM_SOURCES);

   typedef struct packed {
      logic [THREAD_IDX_WIDTH-1:0] thread_idx;
      logic [REG_IDX_WIDTH-1:0]    reg_idx;
      logic                        is_vector;
      logic [DATA_WIDTH-1:0]       value;
      logic [MASK_WIDTH-1:0]       mask;
      logic                        is_last_subcycle;
   } entry_t;

   entry_t                 mem [NUM_SOURCES][QUEUE_DEPTH];
   logic [QUEUE_DEPTH-1:0] live [NUM_SOURCES];
   logic [PTR_W-1:0]       rd_ptr [NUM_SOURCES];
   logic [PTR_W-1:0]       wr_ptr [NUM_SOURCES];
   logic [CNT_W-1:0]       count [NUM_SOURCES];

   entry_t                 src_ent [NUM_SOURCES];
   entry_t                 head [NUM_SOURCES];
   logic [NUM_SOURCES-1:0] push, pop, head_vld, head_live, src_kill, grant_oh;
   logic                   grant_vld;
   logic [SRC_W-1:0]       grant_idx, scan_idx, rr_ptr;

   always_comb begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
         src_ent[i] = '{thread_idx:       src_thread_idx[i*THREAD_IDX_WIDTH +: THREAD_IDX_WIDTH],
                        reg_idx:          src_reg[i*REG_IDX_WIDTH +: REG_IDX_WIDTH],
                        is_vector:        src_is_vector[i],
                        value:            src_value[i*DATA_WIDTH +: DATA_WIDTH],
                        mask:             src_mask[i*MASK_WIDTH +: MASK_WIDTH],
                        is_last_subcycle: src_is_last_subcycle[i]};
         src_ready[i] = (count[i] != CNT_W'(QUEUE_DEPTH));
         push[i]      = src_valid[i] && (count[i] != CNT_W'(QUEUE_DEPTH));
         src_kill[i]  = rollback_en && (src_ent[i].thread_idx == rollback_thread_idx);
         head[i]      = mem[i][rd_ptr[i]];
         head_vld[i]  = (count[i] != '0);
         // A head of the thread being squashed this cycle is already dead.
         head_live[i] = head_vld[i] && live[i][rd_ptr[i]]
                        && !(rollback_en && (head[i].thread_idx == rollback_thread_idx));
      end
   end

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_SOURCES; k++) begin
         scan_idx = (int'(rr_ptr) + k >= NUM_SOURCES) ? SRC_W'(int'(rr_ptr) + k - NUM_SOURCES)
                                                      : SRC_W'(int'(rr_ptr) + k);
         if (!grant_vld && head_live[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
      grant_oh = '0;
      if (grant_vld) grant_oh[grant_idx] = 1'b1;
      // Dead heads drain in parallel without consuming the grant.
      pop = head_vld & (~head_live | grant_oh);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SOURCES; i++)
         if (push[i]) mem[i][wr_ptr[i]] <= src_ent[i];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SOURCES; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
            live[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SOURCES; i++) begin
            for (int j = 0; j < QUEUE_DEPTH; j++)
               if (rollback_en && (mem[i][j].thread_idx == rollback_thread_idx))
                  live[i][j] <= 1'b0;
            if (push[i]) begin
               live[i][wr_ptr[i]] <= !src_kill[i];
               wr_ptr[i]          <= wr_ptr[i] + 1'b1;
            end
            if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
            if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
            else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr                        <= '0;
         wb_writeback_en               <= 1'b0;
         wb_writeback_thread_idx       <= '0;
         wb_writeback_reg              <= '0;
         wb_writeback_is_vector        <= 1'b0;
         wb_writeback_value            <= '0;
         wb_writeback_mask             <= '0;
         wb_writeback_is_last_subcycle <= 1'b0;
         perf_writeback_stall          <= 1'b0;
      end else begin
         wb_writeback_en      <= grant_vld;
         perf_writeback_stall <= |(head_live & ~grant_oh);
         if (grant_vld) begin
            wb_writeback_thread_idx       <= head[grant_idx].thread_idx;
            wb_writeback_reg              <= head[grant_idx].reg_idx;
            wb_writeback_is_vector        <= head[grant_idx].is_vector;
            wb_writeback_value            <= head[grant_idx].value;
            wb_writeback_mask             <= head[grant_idx].mask;
            wb_writeback_is_last_subcycle <= head[grant_idx].is_last_subcycle;
            rr_ptr <= (grant_idx == SRC_W'(NUM_SOURCES - 1)) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SOURCES; i++) begin
            assert (!(pop[i] && count[i] == '0)) else $error("pop from empty queue %0d", i);
            assert (count[i] <= CNT_W'(QUEUE_DEPTH)) else $error("queue %0d overfilled", i);
         end
         assert ($onehot0(grant_oh)) else $error("multiple grants");
      end
   end
endmodule

// File: tb/tb_writeback_merge_queue.sv
// Randomised bench for writeback_merge_queue: a queue-level reference model predicts each
// register-file write, and a negedge monitor scores the DUT against it.
module tb_writeback_merge_queue;
   localparam int N = 3, D = 4, DW = 512, MW = 16, TW = 2, RW = 5;
   localparam int PW = TW + RW + 1 + DW + MW + 1;

   typedef struct {
      logic [TW-1:0] th;
      logic [RW-1:0] rg;
      logic          vec;
      logic [DW-1:0] val;
      logic [MW-1:0] mask;
      logic          last;
      logic          live;
   } ent_t;

   logic              clk, reset;
   logic [N-1:0]      src_valid, src_ready, src_is_vector, src_is_last_subcycle;
   logic [N*TW-1:0]   src_thread_idx;
   logic [N*RW-1:0]   src_reg;
   logic [N*DW-1:0]   src_value;
   logic [N*MW-1:0]   src_mask;
   logic              rollback_en;
   logic [TW-1:0]     rollback_thread_idx;
   logic              wb_writeback_en, wb_writeback_is_vector, wb_writeback_is_last_subcycle;
   logic [TW-1:0]     wb_writeback_thread_idx;
   logic [RW-1:0]     wb_writeback_reg;
   logic [DW-1:0]     wb_writeback_value;
   logic [MW-1:0]     wb_writeback_mask;
   logic              perf_writeback_stall;

   writeback_merge_queue dut (
      .clk(clk), .reset(reset),
      .src_valid(src_valid), .src_ready(src_ready),
      .src_thread_idx(src_thread_idx), .src_reg(src_reg), .src_is_vector(src_is_vector),
      .src_value(src_value), .src_mask(src_mask), .src_is_last_subcycle(src_is_last_subcycle),
      .rollback_en(rollback_en), .rollback_thread_idx(rollback_thread_idx),
      .wb_writeback_en(wb_writeback_en), .wb_writeback_thread_idx(wb_writeback_thread_idx),
      .wb_writeback_reg(wb_writeback_reg), .wb_writeback_is_vector(wb_writeback_is_vector),
      .wb_writeback_value(wb_writeback_value), .wb_writeback_mask(wb_writeback_mask),
      .wb_writeback_is_last_subcycle(wb_writeback_is_last_subcycle),
      .perf_writeback_stall(perf_writeback_stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   compared = 0, mismatched = 0;
   ent_t mq [N][$];
   ent_t exq [$];
   int   rr;
   logic m_en, m_stall;
   logic [N-1:0] m_acc;

   task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [PW-1:0] pk(input ent_t e);
      return {e.th, e.rg, e.vec, e.val, e.mask, e.last};
   endfunction

   function automatic ent_t rand_ent();
      ent_t e;
      e.th   = TW'($urandom);
      e.rg   = RW'($urandom);
      e.vec  = 1'($urandom);
      for (int w = 0; w < DW / 32; w++) e.val[w*32 +: 32] = $urandom;
      e.mask = MW'($urandom);
      e.last = 1'($urandom);
      e.live = 1'b1;
      return e;
   endfunction

   task automatic set_src(input int i, input ent_t e);
      src_thread_idx[i*TW +: TW] = e.th;
      src_reg[i*RW +: RW]        = e.rg;
      src_is_vector[i]           = e.vec;
      src_value[i*DW +: DW]      = e.val;
      src_mask[i*MW +: MW]       = e.mask;
      src_is_last_subcycle[i]    = e.last;
   endtask

   // Reference model: one step per edge over plain per-source queues.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) mq[i].delete();
         exq.delete();
         rr = 0; m_en = 1'b0; m_stall = 1'b0; m_acc = '0;
      end else begin
         bit   hl [N];
         bit   rdy [N];
         int   g;
         ent_t e;
         g = -1;
         for (int i = 0; i < N; i++) begin
            rdy[i] = (mq[i].size() != D);
            hl[i]  = (mq[i].size() > 0) && mq[i][0].live
                     && !(rollback_en && mq[i][0].th == rollback_thread_idx);
         end
         for (int k = 0; k < N; k++)
            if (g < 0 && hl[(rr + k) % N]) g = (rr + k) % N;
         m_stall = 1'b0;
         for (int i = 0; i < N; i++) if (hl[i] && i != g) m_stall = 1'b1;
         m_en = (g >= 0);
         for (int i = 0; i < N; i++) begin
            if (i == g) begin
               exq.push_back(mq[i][0]);
               void'(mq[i].pop_front());
            end else if (mq[i].size() > 0 && !hl[i]) begin
               void'(mq[i].pop_front());
            end
         end
         if (g >= 0) rr = (g + 1) % N;
         if (rollback_en)
            for (int i = 0; i < N; i++)
               for (int j = 0; j < mq[i].size(); j++)
                  if (mq[i][j].th == rollback_thread_idx) mq[i][j].live = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_acc[i] = src_valid[i] && rdy[i];
            if (m_acc[i]) begin
               e.th   = src_thread_idx[i*TW +: TW];
               e.rg   = src_reg[i*RW +: RW];
               e.vec  = src_is_vector[i];
               e.val  = src_value[i*DW +: DW];
               e.mask = src_mask[i*MW +: MW];
               e.last = src_is_last_subcycle[i];
               e.live = !(rollback_en && e.th == rollback_thread_idx);
               mq[i].push_back(e);
            end
         end
      end
   end

   // Monitor: scores strobe, stall, readiness and every written result.
   always @(negedge clk) begin
      if (!reset) begin
         logic [N-1:0] exp_rdy;
         for (int i = 0; i < N; i++) exp_rdy[i] = (mq[i].size() != D);
         chk("wb_en", PW'(wb_writeback_en), PW'(m_en));
         chk("perf_stall", PW'(perf_writeback_stall), PW'(m_stall));
         chk("src_ready", PW'(src_ready), PW'(exp_rdy));
         if (wb_writeback_en) begin
            if (exq.size() == 0) begin
               compared++; mismatched++;
               $display("FAIL wb_unexpected: got a writeback, expected none");
            end else begin
               chk("wb_fields", {wb_writeback_thread_idx, wb_writeback_reg, wb_writeback_is_vector,
                                 wb_writeback_value, wb_writeback_mask,
                                 wb_writeback_is_last_subcycle}, pk(exq.pop_front()));
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic run_random(input int cycles, input int p, input int rbp);
      for (int c = 0; c < cycles; c++) begin
         step();
         for (int i = 0; i < N; i++)
            if (!src_valid[i] || m_acc[i]) begin
               if ($urandom_range(99) < p) begin
                  set_src(i, rand_ent());
                  src_valid[i] = 1'b1;
               end else begin
                  src_valid[i] = 1'b0;
               end
            end
         rollback_en         = ($urandom_range(99) < rbp);
         rollback_thread_idx = TW'($urandom);
      end
   endtask

   task automatic idle(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         step();
         src_valid   = '0;
         rollback_en = 1'b0;
      end
   endtask

   ent_t ce [N][2];
   ent_t se;
   int   order [6];
   int   total;

   initial begin
      reset = 1'b1; src_valid = '0; rollback_en = 1'b0; rollback_thread_idx = '0;
      src_thread_idx = '0; src_reg = '0; src_is_vector = '0; src_value = '0;
      src_mask = '0; src_is_last_subcycle = '0;
      #1;
      chk("reset_wb_en", PW'(wb_writeback_en), PW'(0));
      chk("reset_stall", PW'(perf_writeback_stall), PW'(0));
      step(); step();
      reset = 1'b0;
      chk("post_reset_ready", PW'(src_ready), PW'(3'b111));

      // Contention: two results from every source, granted src0,src1,src2 twice.
      order = '{0, 1, 2, 0, 1, 2};
      for (int r = 0; r < 2; r++) begin
         step();
         for (int i = 0; i < N; i++) begin
            ce[i][r] = rand_ent();
            set_src(i, ce[i][r]);
         end
         src_valid = '1;
      end
      step();
      src_valid = '0;
      for (int n = 0; n < 6; n++) begin
         chk("contention_en", PW'(wb_writeback_en), PW'(1));
         chk("contention_order", PW'(wb_writeback_value), PW'(ce[order[n]][n / 3].val));
         step();
      end
      chk("contention_idle", PW'(wb_writeback_en), PW'(0));
      idle(3);

      // Single uncontended result: strobe in the cycle after the second edge.
      step();
      se = rand_ent();
      se.th = 2'd1; se.rg = 5'd5; se.val[7:0] = 8'hAB; se.mask = 16'hFFFF;
      set_src(0, se);
      src_valid = 3'b001;
      step();
      src_valid = '0;
      chk("single_not_yet", PW'(wb_writeback_en), PW'(0));
      step();
      chk("single_en", PW'(wb_writeback_en), PW'(1));
      chk("single_fields", {wb_writeback_thread_idx, wb_writeback_reg, wb_writeback_mask,
                            wb_writeback_value[7:0]}, PW'({2'd1, 5'd5, 16'hFFFF, 8'hAB}));
      step();
      chk("single_idle", PW'(wb_writeback_en), PW'(0));

      // Heavy load fills queues; then mixed load with rollbacks.
      run_random(300, 95, 0);
      run_random(1500, 60, 8);
      idle(20);
      total = 0;
      for (int i = 0; i < N; i++) total += mq[i].size();
      chk("drain_queues_empty", PW'(total), PW'(0));
      chk("drain_scoreboard_empty", PW'(exq.size()), PW'(0));

      // Asynchronous reset with results still queued.
      run_random(12, 100, 0);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_en", PW'(wb_writeback_en), PW'(0));
      chk("async_rst_stall", PW'(perf_writeback_stall), PW'(0));
      chk("async_rst_value", PW'(wb_writeback_value), PW'(0));
      chk("async_rst_reg", PW'(wb_writeback_reg), PW'(0));
      src_valid = '0;
      step(); step();
      reset = 1'b0;
      chk("rst_release_ready", PW'(src_ready), PW'(3'b111));
      idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
